// File: rtl/move_issuer_pkg.sv
// move_issuer_pkg: shared state codes, error codes and board geometry for the move issuer.
package move_issuer_pkg;
  localparam int SIDE = 5;
  localparam int CELLS = 25;
  localparam int IDX_W = 5;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    LOCK  = 3'd4
  } state_t;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_OFF     = 3'd1,
    ERR_CLEARED = 3'd2,
    ERR_OVER    = 3'd3,
    ERR_BUSY    = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_t;
endpackage

// File: rtl/move_issuer_cell_index.sv
// move_issuer_cell_index: row/col to linear cell index plus off-board flag.
module move_issuer_cell_index
  import move_issuer_pkg::*;
(
  input  logic [2:0]       row,
  input  logic [2:0]       col,
  output logic [IDX_W-1:0] idx,
  output logic             off
);
  assign off = (row >= 3'(SIDE)) || (col >= 3'(SIDE));
  assign idx = IDX_W'(row) * IDX_W'(SIDE) + IDX_W'(col);
endmodule

// File: rtl/move_issuer.sv
// move_issuer: screens keypad strikes and drives the game's one-cycle move handshake with retries.
module move_issuer
  import move_issuer_pkg::*;
#(
  parameter int RETRY_CYCLES = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic             in_clka,
  input  logic             in_restart,
  input  logic             in_key,
  input  logic [2:0]       in_row,
  input  logic [2:0]       in_col,
  input  logic [CELLS-1:0] in_cleared,
  input  logic             in_ready,
  input  logic             in_gameover,
  input  logic             in_win,
  output logic             out_data_in,
  output logic [IDX_W-1:0] out_data,
  output logic             out_busy,
  output logic             out_reject,
  output logic [2:0]       out_err,
  output logic [7:0]       out_moves,
  output logic [2:0]       out_state
);
  localparam int WW = $clog2(RETRY_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, nxt;
  logic [2:0] row, col, err, err_n;
  logic [IDX_W-1:0] idx, data;
  logic off, over, fire, expire, rej_n, reject;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] retry;
  logic [7:0] moves;
  move_issuer_cell_index u_idx (.row(row), .col(col), .idx(idx), .off(off));
  assign over = in_gameover | in_win;
  assign fire = (state == ISSUE) && in_ready && !over && !in_restart;
  assign expire = (state == WAIT) && in_ready && (wcnt == WW'(RETRY_CYCLES - 1));
  assign out_data_in = fire;
  assign out_data = fire ? idx : data;
  assign out_busy = state inside {CHECK, ISSUE, WAIT};
  assign out_reject = reject;
  assign out_err = err;
  assign out_moves = moves;
  assign out_state = state;
  always_comb begin
    nxt = state;
    rej_n = 1'b0;
    err_n = err;
    case (state)
      IDLE: nxt = in_key ? CHECK : IDLE;
      CHECK: begin
        if (over) begin
          nxt = LOCK; rej_n = 1'b1; err_n = ERR_OVER;
        end else if (off) begin
          nxt = IDLE; rej_n = 1'b1; err_n = ERR_OFF;
        end else if (in_cleared[idx]) begin
          nxt = IDLE; rej_n = 1'b1; err_n = ERR_CLEARED;
        end else begin
          nxt = ISSUE; err_n = ERR_NONE;
        end
      end
      ISSUE: nxt = over ? LOCK : in_ready ? WAIT : ISSUE;
      WAIT: begin
        if (over) nxt = LOCK;
        else if (!in_ready) nxt = IDLE;
        else if (expire && retry < RW'(MAX_RETRY)) nxt = ISSUE;
        else if (expire) begin
          nxt = IDLE; rej_n = 1'b1; err_n = ERR_TIMEOUT;
        end
      end
      LOCK: begin
        rej_n = in_key;
        err_n = in_key ? ERR_OVER : err;
      end
      default: nxt = IDLE;
    endcase
    // a stray key only reports busy when the FSM itself has nothing to refuse this cycle
    if (in_key && out_busy && !rej_n) begin
      rej_n = 1'b1;
      err_n = ERR_BUSY;
    end
  end
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      data <= '0;
      reject <= 1'b0;
      err <= ERR_NONE;
      moves <= '0;
      wcnt <= '0;
      retry <= '0;
    end else begin
      state <= nxt;
      reject <= rej_n;
      err <= err_n;
      wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
      if (state == IDLE && in_key) begin
        row <= in_row;
        col <= in_col;
      end
      if (fire) data <= idx;
      if (state == WAIT && !over) begin
        if (!in_ready) begin
          moves <= moves + 8'(moves != 8'hFF);
          retry <= '0;
        end else if (expire) retry <= (retry < RW'(MAX_RETRY)) ? retry + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_move_issuer.sv
// tb_move_issuer: table, random and hand-written sequence checks of move_issuer against a transaction-level model.
module tb_move_issuer;
  logic clk = 1'b0;
  logic in_restart = 1'b1, in_key = 1'b0, in_ready = 1'b0, in_gameover = 1'b0, in_win = 1'b0;
  logic [2:0] in_row = '0, in_col = '0;
  logic [24:0] in_cleared = '0;
  logic out_data_in, out_busy, out_reject;
  logic [4:0] out_data;
  logic [2:0] out_err, out_state;
  logic [7:0] out_moves;
  int checks = 0, passed = 0, moves_m = 0;
  always #5 clk = ~clk;
  move_issuer #(.RETRY_CYCLES(8), .MAX_RETRY(3)) dut (
    .in_clka(clk), .in_restart(in_restart), .in_key(in_key), .in_row(in_row), .in_col(in_col),
    .in_cleared(in_cleared), .in_ready(in_ready), .in_gameover(in_gameover), .in_win(in_win),
    .out_data_in(out_data_in), .out_data(out_data), .out_busy(out_busy), .out_reject(out_reject),
    .out_err(out_err), .out_moves(out_moves), .out_state(out_state)
  );
  typedef struct {
    int r; int c; logic [24:0] m; int rd; int acc; int bk; int err; int pulse; int idx;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_state"}, out_state, 0);
    chk({tag, "_err"}, out_err, 0);
    chk({tag, "_moves"}, out_moves, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_busy"}, out_busy, 0);
    chk({tag, "_reject"}, out_reject, 0);
    chk({tag, "_data_in"}, out_data_in, 0);
  endtask
  function automatic int model_err(input int r, input int c, input logic [24:0] m);
    if (r > 4 || c > 4) return 1;
    if (m[r * 5 + c]) return 2;
    return 0;
  endfunction
  // Runs one keypad move from a negedge; ready rises rd cycles after the key and drops acc cycles after the pulse.
  task automatic do_move(input int r, input int c, input logic [24:0] m, input int rd, input int acc,
                         input int bk, input int ex_err, input int ex_pulse, input int ex_idx);
    int np, pt, pd, nrej;
    bit prev, done;
    np = 0; pt = -1; pd = 0; nrej = 0; prev = 0; done = 0;
    in_row = 3'(r); in_col = 3'(c); in_cleared = m; in_key = 1'b1; in_ready = (rd == 0);
    for (int t = 0; t < 60 && !done; t++) begin
      #2;
      if (out_data_in) begin
        if (prev) chk("double_pulse", 1, 0);
        np++; pt = t; pd = out_data;
      end
      prev = out_data_in;
      if (out_reject) nrej++;
      if (t >= 2 && out_state == 0) done = 1;
      else begin
        @(negedge clk);
        in_key = (t + 1 == bk);
        in_ready = (np == 0) ? (t + 1 >= rd) : (t + 1 - pt <= acc);
      end
    end
    chk("move_done", done, 1);
    chk("pulses", np, ex_pulse);
    if (ex_pulse != 0 && np > 0) chk("index", pd, ex_idx);
    if (rd == 0 && ex_pulse != 0) chk("latency", pt, 2);
    chk("rejects", nrej, ex_err != 0);
    chk("err", out_err, ex_err);
    if (ex_pulse != 0 && moves_m < 255) moves_m++;
    chk("moves", out_moves, moves_m);
    @(negedge clk);
  endtask
  initial begin
    int pts[$];
    int r, c, rd, acc, e, nrej;
    logic [24:0] m;
    bit done;
    tbl[0] = '{0, 2, 25'd0, 0, 1, -1, 0, 1, 2};
    tbl[1] = '{1, 0, 25'h20, 0, 1, -1, 2, 0, 0};
    tbl[2] = '{5, 1, 25'd0, 0, 1, -1, 1, 0, 0};
    tbl[3] = '{4, 4, 25'd0, 3, 2, -1, 0, 1, 24};
    tbl[4] = '{2, 5, 25'd0, 0, 0, -1, 1, 0, 0};
    tbl[5] = '{3, 4, 25'd0, 0, 3, 3, 4, 1, 19};
    tbl[6] = '{4, 0, 25'h100000, 0, 1, -1, 2, 0, 0};
    tbl[7] = '{0, 0, 25'h1FFFFFE, 1, 0, -1, 0, 1, 0};
    repeat (3) @(negedge clk);
    in_ready = 1'b1;
    #2 chk_idle_zero("reset");
    @(negedge clk);
    in_restart = 1'b0;
    @(negedge clk);
    foreach (tbl[i])
      do_move(tbl[i].r, tbl[i].c, tbl[i].m, tbl[i].rd, tbl[i].acc, tbl[i].bk,
              tbl[i].err, tbl[i].pulse, tbl[i].idx);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5); c = $urandom_range(0, 5);
      m = 25'($urandom & $urandom);
      rd = $urandom_range(0, 3); acc = $urandom_range(0, 4);
      e = model_err(r, c, m);
      do_move(r, c, m, rd, acc, -1, e, e == 0, (r * 5 + c) % 32);
    end
    // ready never drops: initial pulse plus three re-issues, then timeout
    in_row = 3'd2; in_col = 3'd3; in_cleared = '0; in_ready = 1'b1; in_key = 1'b1;
    nrej = 0; done = 0;
    for (int t = 0; t < 80 && !done; t++) begin
      #2;
      if (out_data_in) pts.push_back(t);
      if (out_reject) nrej++;
      if (t >= 2 && out_state == 0) done = 1;
      else begin
        @(negedge clk);
        in_key = 1'b0;
      end
    end
    chk("retry_done", done, 1);
    chk("retry_pulses", pts.size(), 4);
    if (pts.size() > 0) chk("retry_first", pts[0], 2);
    for (int i = 1; i < pts.size(); i++) chk("retry_gap", pts[i] - pts[i - 1], 9);
    chk("timeout_err", out_err, 5);
    chk("timeout_reject", nrej, 1);
    chk("timeout_moves", out_moves, moves_m);
    @(negedge clk);
    in_row = 3'd1; in_col = 3'd1; in_ready = 1'b0; in_key = 1'b1;
    @(negedge clk);
    in_key = 1'b0;
    @(negedge clk);
    in_ready = 1'b1; in_gameover = 1'b1;
    #2 chk("go_issue_state", out_state, 2);
    chk("go_no_pulse", out_data_in, 0);
    @(negedge clk);
    #2 chk("go_lock_state", out_state, 4);
    chk("go_lock_busy", out_busy, 0);
    chk("go_lock_no_pulse", out_data_in, 0);
    @(negedge clk);
    in_gameover = 1'b0; in_key = 1'b1;
    @(negedge clk);
    in_key = 1'b0;
    #2 chk("lock_reject", out_reject, 1);
    chk("lock_err", out_err, 3);
    chk("lock_state", out_state, 4);
    @(negedge clk);
    in_restart = 1'b1;
    @(negedge clk);
    in_restart = 1'b0;
    #2 chk_idle_zero("restart");
    moves_m = 0;
    @(negedge clk);
    in_row = 3'd0; in_col = 3'd0; in_key = 1'b1; in_win = 1'b1;
    @(negedge clk);
    in_key = 1'b0;
    @(negedge clk);
    #2 chk("keywin_reject", out_reject, 1);
    chk("keywin_err", out_err, 3);
    chk("keywin_state", out_state, 4);
    @(negedge clk);
    in_win = 1'b0; in_restart = 1'b1;
    @(negedge clk);
    in_restart = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 257; i++) do_move(0, 0, 25'd0, 0, 0, -1, 0, 1, 0);
    chk("saturate", out_moves, 255);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
